// File: rtl/mux_rr_arbiter_pkg.sv
// Shared FSM encoding and requester-count helper for the round-robin mux arbiter.
// No logic of its own; imported by the arbiter top and its pick sub-module.
package mux_rr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic int num_req(input int select_lines);
      return 1 << select_lines;
   endfunction

endpackage

// File: rtl/mux.sv
// Generic 2**SELECT_LINES : 1 data mux, combinational (zero latency).
// No flow control; the select is owned entirely by the caller.
module mux #(
   parameter string ARCHITECTURE = "BEHAVIORAL",
   parameter int    SELECT_LINES = 1,
   parameter int    DATA_WIDTH   = 8
) (
   input  logic [DATA_WIDTH*(2**SELECT_LINES)-1:0] in_data,
   input  logic [SELECT_LINES-1:0]                 select,
   output logic [DATA_WIDTH-1:0]                   out_data
);

   localparam int N = 2 ** SELECT_LINES;

   if (ARCHITECTURE == "BEHAVIORAL") begin : g_behav
      always_comb begin
         out_data = in_data[DATA_WIDTH*select +: DATA_WIDTH];
      end
   end else begin : g_andor
      // Explicit AND-OR form for flows that dislike variable part-selects.
      always_comb begin
         out_data = '0;
         for (int k = 0; k < N; k++) begin
            out_data = out_data
                     | (in_data[DATA_WIDTH*k +: DATA_WIDTH] & {DATA_WIDTH{select == SELECT_LINES'(k)}});
         end
      end
   end

endmodule

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Round-robin pick: first set req bit after last_grant, wrapping; combinational.
// No flow control; found=0 when nothing is requesting.
module mux_rr_arbiter_rr_pick
   import mux_rr_arbiter_pkg::*;
#(
   parameter int SELECT_LINES = 2,
   localparam int N = num_req(SELECT_LINES)
) (
   input  logic [N-1:0]            req,
   input  logic [SELECT_LINES-1:0] last_grant,
   output logic                    found,
   output logic [SELECT_LINES-1:0] index
);

   logic [SELECT_LINES-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest requester wins;
   // offset N wraps back to last_grant itself, the lowest priority.
   always_comb begin
      found = 1'b0;
      index = last_grant;
      cand  = last_grant;
      for (int i = N; i >= 1; i--) begin
         cand = last_grant + SELECT_LINES'(i);
         if (req[cand]) begin
            found = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin packet arbiter feeding one registered valid/ready stream; beats appear 1 cycle after accept.
// Holds grant to end of packet; in_ready drops while the output register is full and stalled.
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter string BLOCK_NAME   = "mux_rr_arbiter",
   parameter int    X            = 0,
   parameter int    Y            = 0,
   parameter int    DX           = 0,
   parameter int    DY           = 0,
   parameter int    SELECT_LINES = 2,
   parameter int    DATA_WIDTH   = 8,
   localparam int   N            = num_req(SELECT_LINES)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N-1:0]            in_valid,
   input  logic [N-1:0]            in_last,
   input  logic [DATA_WIDTH*N-1:0] in_data,
   output logic [N-1:0]            in_ready,
   output logic                    out_valid,
   output logic                    out_last,
   output logic [DATA_WIDTH-1:0]   out_data,
   input  logic                    out_ready,
   output logic [SELECT_LINES-1:0] out_select,
   output logic                    busy
);

   if ((SELECT_LINES < 1) || (X < 0) || (Y < 0) || (DX < 0) || (DY < 0) || (BLOCK_NAME == "")) begin : g_param_check
      $error("mux_rr_arbiter: illegal parameter set");
   end

   state_t                  state_q, state_d;
   logic [SELECT_LINES-1:0] grant_q, grant_d;
   logic [SELECT_LINES-1:0] last_grant_q, last_grant_d;
   logic                    out_valid_d, out_last_d;
   logic [DATA_WIDTH-1:0]   out_data_d;
   logic                    found;
   logic [SELECT_LINES-1:0] pick;
   logic [DATA_WIDTH-1:0]   mux_data;
   logic                    load;
   logic                    xfer;

   mux_rr_arbiter_rr_pick #(.SELECT_LINES(SELECT_LINES)) u_pick (
      .req        (in_valid),
      .last_grant (last_grant_q),
      .found      (found),
      .index      (pick)
   );

   mux #(
      .ARCHITECTURE ("BEHAVIORAL"),
      .SELECT_LINES (SELECT_LINES),
      .DATA_WIDTH   (DATA_WIDTH)
   ) u_mux (
      .in_data  (in_data),
      .select   (out_select),
      .out_data (mux_data)
   );

   assign out_select = grant_q;
   assign busy       = (state_q == GRANT);
   assign load       = !out_valid || out_ready;
   assign xfer       = busy && in_valid[grant_q] && load;

   always_comb begin
      in_ready = '0;
      if (busy) begin
         in_ready[grant_q] = load;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      out_valid_d  = out_valid;
      out_last_d   = out_last;
      out_data_d   = out_data;
      // A drained output register empties unless refilled by a transfer below.
      if (out_ready) begin
         out_valid_d = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = pick;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (xfer) begin
               out_data_d  = mux_data;
               out_last_d  = in_last[grant_q];
               out_valid_d = 1'b1;
               if (in_last[grant_q]) begin
                  last_grant_d = grant_q;
                  state_d      = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= '1;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         out_data     <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         out_valid    <= out_valid_d;
         out_last     <= out_last_d;
         out_data     <= out_data_d;
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench: 4-requester/8-bit arbiter plus a 2-requester/32-bit instance.
module tb_mux_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          total = 0;
   int          bad = 0;

   logic [3:0]  a_in_valid, a_in_last, a_in_ready;
   logic [31:0] a_in_data;
   logic        a_out_valid, a_out_last, a_out_ready, a_busy;
   logic [7:0]  a_out_data;
   logic [1:0]  a_out_select;

   logic [1:0]  b_in_valid, b_in_last, b_in_ready;
   logic [63:0] b_in_data;
   logic        b_out_valid, b_out_last, b_out_ready, b_busy;
   logic [31:0] b_out_data;
   logic [0:0]  b_out_select;

   always #5 clk = ~clk;

   mux_rr_arbiter #(.SELECT_LINES(2), .DATA_WIDTH(8)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_last(a_in_last), .in_data(a_in_data), .in_ready(a_in_ready),
      .out_valid(a_out_valid), .out_last(a_out_last), .out_data(a_out_data), .out_ready(a_out_ready),
      .out_select(a_out_select), .busy(a_busy)
   );

   mux_rr_arbiter #(.SELECT_LINES(1), .DATA_WIDTH(32)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_last(b_in_last), .in_data(b_in_data), .in_ready(b_in_ready),
      .out_valid(b_out_valid), .out_last(b_out_last), .out_data(b_out_data), .out_ready(b_out_ready),
      .out_select(b_out_select), .busy(b_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      a_in_valid = '0; a_in_last = '0; a_in_data = '0; a_out_ready = 1'b1;
      b_in_valid = '0; b_in_last = '0; b_in_data = '0; b_out_ready = 1'b1;
      tick();
      tick();
      check("rst_out_valid", 32'(a_out_valid), 32'd0);
      check("rst_out_last", 32'(a_out_last), 32'd0);
      check("rst_out_data", 32'(a_out_data), 32'd0);
      check("rst_in_ready", 32'(a_in_ready), 32'd0);
      check("rst_out_select", 32'(a_out_select), 32'd0);
      check("rst_busy", 32'(a_busy), 32'd0);
      rst_n = 1'b1;

      // 1: requester 2, three beats
      a_in_valid = 4'b0100; a_in_data[23:16] = 8'h11;
      tick();
      check("t1_busy", 32'(a_busy), 32'd1);
      check("t1_select", 32'(a_out_select), 32'd2);
      check("t1_in_ready", 32'(a_in_ready), 32'h4);
      check("t1_no_out_yet", 32'(a_out_valid), 32'd0);
      tick();
      check("t1_b0_valid", 32'(a_out_valid), 32'd1);
      check("t1_b0_data", 32'(a_out_data), 32'h11);
      check("t1_b0_last", 32'(a_out_last), 32'd0);
      a_in_data[23:16] = 8'h22;
      tick();
      check("t1_b1_data", 32'(a_out_data), 32'h22);
      check("t1_b1_select", 32'(a_out_select), 32'd2);
      a_in_data[23:16] = 8'h33; a_in_last = 4'b0100;
      tick();
      check("t1_b2_data", 32'(a_out_data), 32'h33);
      check("t1_b2_last", 32'(a_out_last), 32'd1);
      check("t1_b2_select", 32'(a_out_select), 32'd2);
      check("t1_idle_busy", 32'(a_busy), 32'd0);
      check("t1_idle_ready", 32'(a_in_ready), 32'd0);
      a_in_valid = '0; a_in_last = '0;
      tick();
      check("t1_drain", 32'(a_out_valid), 32'd0);

      // 2: all four requesters, single-beat packets, rotation from reset
      do_reset();
      a_in_valid = 4'hF; a_in_last = 4'hF; a_in_data = 32'hA3A2A1A0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t2_select", 32'(a_out_select), 32'(i % 4));
         check("t2_in_ready", 32'(a_in_ready), 32'(1 << (i % 4)));
         tick();
         check("t2_data", 32'(a_out_data), 32'hA0 + 32'(i % 4));
         check("t2_last", 32'(a_out_last), 32'd1);
         check("t2_bubble_busy", 32'(a_busy), 32'd0);
         check("t2_bubble_ready", 32'(a_in_ready), 32'd0);
      end
      a_in_valid = '0; a_in_last = '0;
      tick();

      // 3: backpressure mid-packet on requester 1
      a_in_valid = 4'b0010; a_in_data[15:8] = 8'h51;
      tick();
      check("t3_select", 32'(a_out_select), 32'd1);
      tick();
      check("t3_b0_data", 32'(a_out_data), 32'h51);
      a_in_data[15:8] = 8'h52; a_out_ready = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("t3_hold_ready", 32'(a_in_ready), 32'd0);
         tick();
         check("t3_hold_valid", 32'(a_out_valid), 32'd1);
         check("t3_hold_data", 32'(a_out_data), 32'h51);
      end
      a_out_ready = 1'b1;
      #1;
      check("t3_release_ready", 32'(a_in_ready), 32'h2);
      tick();
      check("t3_b1_data", 32'(a_out_data), 32'h52);
      a_in_data[15:8] = 8'h53;
      tick();
      check("t3_b2_data", 32'(a_out_data), 32'h53);
      a_in_data[15:8] = 8'h54; a_in_last = 4'b0010;
      tick();
      check("t3_b3_data", 32'(a_out_data), 32'h54);
      check("t3_b3_last", 32'(a_out_last), 32'd1);
      a_in_valid = '0; a_in_last = '0;
      tick();

      // 4: granted requester 2 gaps while 0 and 3 keep requesting
      a_in_valid = 4'b1101; a_in_data = 32'h3F61000F;
      tick();
      check("t4_select", 32'(a_out_select), 32'd2);
      tick();
      check("t4_b0_data", 32'(a_out_data), 32'h61);
      a_in_valid = 4'b1001;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_gap_select", 32'(a_out_select), 32'd2);
         check("t4_gap_busy", 32'(a_busy), 32'd1);
         check("t4_gap_ready", 32'(a_in_ready), 32'h4);
         check("t4_gap_valid", 32'(a_out_valid), 32'd0);
      end
      a_in_valid = 4'b1101; a_in_data[23:16] = 8'h62; a_in_last = 4'b0100;
      tick();
      check("t4_b1_data", 32'(a_out_data), 32'h62);
      check("t4_b1_last", 32'(a_out_last), 32'd1);
      a_in_last = '0; a_in_data[31:24] = 8'h71;
      tick();
      check("t4_next_select", 32'(a_out_select), 32'd3);

      // 5: asynchronous reset in the middle of requester 3's packet
      tick();
      check("t5_pre_valid", 32'(a_out_valid), 32'd1);
      check("t5_pre_data", 32'(a_out_data), 32'h71);
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_valid", 32'(a_out_valid), 32'd0);
      check("t5_async_ready", 32'(a_in_ready), 32'd0);
      check("t5_async_busy", 32'(a_busy), 32'd0);
      #1 rst_n = 1'b1;
      a_in_valid = 4'hF;
      tick();
      check("t5_prio_select", 32'(a_out_select), 32'd0);
      a_in_valid = '0;

      // 6: two requesters, 32-bit data, alternation
      b_in_valid = 2'b11; b_in_last = 2'b11; b_in_data = 64'hBBBB0001_AAAA0000;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t6_select", 32'(b_out_select), 32'(i % 2));
         check("t6_in_ready", 32'(b_in_ready), 32'(1 << (i % 2)));
         tick();
         check("t6_data", b_out_data, (i % 2 == 1) ? 32'hBBBB0001 : 32'hAAAA0000);
         check("t6_last", 32'(b_out_last), 32'd1);
      end
      b_in_valid = '0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
